// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: drives a req/ack data-memory bus, forms store lanes and strobes,
// extends load data for MEM/WB, and stalls the pipeline while an access is outstanding.
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_MemAcc,
    input  logic        rstn_MemAcc,
    input  logic        valid_MemAcc,
    input  logic        MemRead_MemAcc,
    input  logic        MemWrite_MemAcc,
    input  logic [2:0]  funct3_MemAcc,
    input  logic [31:0] ALU_in_MemAcc,
    input  logic [31:0] Data_in_MemAcc,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [31:0] DMem_data_MemAcc,
    output logic        stall_MemAcc,
    output logic        misalign_MemAcc,
    output logic        bus_err_MemAcc
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [31:0]   dmem_q, dmem_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    lo_q, lo_d;

    logic          is_mem;
    logic          bad_align;
    logic          start;
    logic [31:0]   st_wdata;
    logic [3:0]    st_wstrb;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_data;

    assign is_mem = valid_MemAcc & (MemRead_MemAcc | MemWrite_MemAcc);

    // Undefined widths (011/110/111) are folded into the misalign path so they never reach the bus.
    always_comb begin
        unique case (funct3_MemAcc)
            3'b000, 3'b100: bad_align = 1'b0;
            3'b001, 3'b101: bad_align = ALU_in_MemAcc[0];
            3'b010:         bad_align = (ALU_in_MemAcc[1:0] != 2'b00);
            default:        bad_align = 1'b1;
        endcase
    end

    assign misalign_MemAcc = is_mem & bad_align;
    assign start           = (state_q == S_IDLE) & is_mem & ~bad_align;
    assign stall_MemAcc    = rstn_MemAcc & (start | (state_q == S_BUSY));

    always_comb begin
        unique case (funct3_MemAcc[1:0])
            2'b00: begin
                st_wdata = {4{Data_in_MemAcc[7:0]}};
                st_wstrb = 4'b0001 << ALU_in_MemAcc[1:0];
            end
            2'b01: begin
                st_wdata = {2{Data_in_MemAcc[15:0]}};
                st_wstrb = 4'b0011 << {ALU_in_MemAcc[1], 1'b0};
            end
            default: begin
                st_wdata = Data_in_MemAcc;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    assign ld_byte = 8'(bus_rdata >> {lo_q, 3'b000});
    assign ld_half = 16'(bus_rdata >> {lo_q[1], 4'b0000});

    always_comb begin
        unique case (f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = bus_rdata;
        endcase
    end

    always_comb begin
        // NOTE: every next-state signal defaults to its register so no path leaves it unassigned (no latches).
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        dmem_d  = dmem_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        lo_d    = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_BUSY;
                    req_d   = 1'b1;
                    we_d    = MemWrite_MemAcc;
                    addr_d  = {ALU_in_MemAcc[31:2], 2'b00};
                    wdata_d = st_wdata;
                    wstrb_d = MemWrite_MemAcc ? st_wstrb : 4'b0000;
                    f3_d    = funct3_MemAcc;
                    lo_d    = ALU_in_MemAcc[1:0];
                    cnt_d   = '0;
                end
            end
            S_BUSY: begin
                if (bus_ack) begin
                    if (!we_q) dmem_d = ld_data;
                    req_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    dmem_d  = 32'h0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // One unstalled cycle lets the pipeline advance past the finished instruction.
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk_MemAcc or negedge rstn_MemAcc) begin
        if (!rstn_MemAcc) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'h0;
            dmem_q  <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            f3_q    <= 3'b000;
            lo_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            dmem_q  <= dmem_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            lo_q    <= lo_d;
        end
    end

    assign bus_req          = req_q;
    assign bus_we           = we_q;
    assign bus_addr         = addr_q;
    assign bus_wdata        = wdata_q;
    assign bus_wstrb        = wstrb_q;
    assign DMem_data_MemAcc = dmem_q;
    assign bus_err_MemAcc   = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases plus randomized loads/stores checked against
// an arithmetic model of access width, lane placement, extension and timing.
module tb_mem_access_stage;

    logic        clk_MemAcc = 1'b0;
    logic        rstn_MemAcc;
    logic        valid_MemAcc, MemRead_MemAcc, MemWrite_MemAcc;
    logic [2:0]  funct3_MemAcc;
    logic [31:0] ALU_in_MemAcc, Data_in_MemAcc;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic [31:0] DMem_data_MemAcc;
    logic        stall_MemAcc, misalign_MemAcc, bus_err_MemAcc;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_dmem;

    localparam int TMO = 16;

    mem_access_stage #(.TIMEOUT(TMO)) dut (
        .clk_MemAcc(clk_MemAcc), .rstn_MemAcc(rstn_MemAcc), .valid_MemAcc(valid_MemAcc),
        .MemRead_MemAcc(MemRead_MemAcc), .MemWrite_MemAcc(MemWrite_MemAcc),
        .funct3_MemAcc(funct3_MemAcc), .ALU_in_MemAcc(ALU_in_MemAcc), .Data_in_MemAcc(Data_in_MemAcc),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .DMem_data_MemAcc(DMem_data_MemAcc), .stall_MemAcc(stall_MemAcc),
        .misalign_MemAcc(misalign_MemAcc), .bus_err_MemAcc(bus_err_MemAcc)
    );

    always #5 clk_MemAcc = ~clk_MemAcc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int model_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit model_bad(input logic [2:0] f3, input logic [31:0] a);
        if (!(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
        return (a % model_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] w);
        int unsigned sz, v, lim;
        sz = model_size(f3);
        if (sz == 4) return w;
        v   = w >> (8 * (a % 4));
        lim = 32'd1 << (8 * sz);
        v   = v % lim;
        if ((f3 == 3'd0 || f3 == 3'd1) && v >= lim / 2) v = v - lim;
        return v;
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] s;
        int sz;
        sz = model_size(f3);
        for (int i = 0; i < 4; i++) s[i] = ((i / sz) == ((a % 4) / sz));
        return s;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        int sz;
        sz = model_size(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
        return r;
    endfunction

    // ---------------- stimulus driver (caller is at posedge+1) ----------------
    task automatic run_access(input logic vld, rd, wr, input logic [2:0] f3,
                              input logic [31:0] a, d, rdat, input int ack_delay,
                              output int stall_n, output int req_n, output logic mis,
                              output logic [31:0] o_addr, output logic [31:0] o_wdata,
                              output logic [3:0] o_wstrb, output logic o_we,
                              output int unstable, output logic [31:0] o_dmem,
                              output logic done_ok);
        bit first;
        valid_MemAcc = vld; MemRead_MemAcc = rd; MemWrite_MemAcc = wr;
        funct3_MemAcc = f3; ALU_in_MemAcc = a; Data_in_MemAcc = d; bus_rdata = rdat;
        stall_n = 0; req_n = 0; unstable = 0; done_ok = 1'b0; first = 1'b1; mis = 1'b0;
        o_addr = '0; o_wdata = '0; o_wstrb = '0; o_we = 1'b0; o_dmem = '0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk_MemAcc);
            if (first) mis = misalign_MemAcc;
            first = 1'b0;
            if (bus_req) begin
                if (req_n == 0) begin
                    o_addr = bus_addr; o_wdata = bus_wdata; o_wstrb = bus_wstrb; o_we = bus_we;
                end else if (bus_addr !== o_addr || bus_wdata !== o_wdata ||
                             bus_wstrb !== o_wstrb || bus_we !== o_we) begin
                    unstable++;
                end
                if (req_n == ack_delay) bus_ack = 1'b1;
                req_n++;
            end
            if (!stall_MemAcc) begin
                o_dmem = DMem_data_MemAcc;
                done_ok = 1'b1;
            end else begin
                stall_n++;
            end
            @(posedge clk_MemAcc); #1;
            bus_ack = 1'b0;
            if (done_ok) break;
        end
        valid_MemAcc = 1'b0; MemRead_MemAcc = 1'b0; MemWrite_MemAcc = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn_MemAcc = 1'b0;
        valid_MemAcc = 1'b1; MemRead_MemAcc = 1'b1; MemWrite_MemAcc = 1'b0;
        funct3_MemAcc = 3'b010; ALU_in_MemAcc = 32'h100; Data_in_MemAcc = 32'h0;
        bus_rdata = 32'h0; bus_ack = 1'b0;
        #23;
        checks++;
        if (stall_MemAcc !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b expected 0", stall_MemAcc);
        end
        checks++;
        if ({bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb} !== '0) begin
            errors++; $display("FAIL reset_bus: req=%b we=%b addr=%h wdata=%h strb=%b expected all 0",
                               bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb);
        end
        checks++;
        if (DMem_data_MemAcc !== 32'h0 || bus_err_MemAcc !== 1'b0) begin
            errors++; $display("FAIL reset_data: dmem=%h err=%b expected 0/0", DMem_data_MemAcc, bus_err_MemAcc);
        end
        valid_MemAcc = 1'b0; MemRead_MemAcc = 1'b0;
        @(negedge clk_MemAcc);
        rstn_MemAcc = 1'b1;
        @(posedge clk_MemAcc); #1;
        exp_dmem = 32'h0;
    endtask

    task automatic test_load_word();
        int sn, rn, un; logic mis, we, ok; logic [31:0] ad, wd, dm; logic [3:0] st;
        run_access(1, 1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0,
                   sn, rn, mis, ad, wd, st, we, un, dm, ok);
        exp_dmem = 32'hDEADBEEF;
        checks++;
        if (!ok || sn != 2 || rn != 1) begin
            errors++; $display("FAIL lw_timing: done=%b stall=%0d req=%0d expected 1/2/1", ok, sn, rn);
        end
        checks++;
        if (ad !== 32'h100 || st !== 4'b0000 || we !== 1'b0) begin
            errors++; $display("FAIL lw_bus: addr=%h strb=%b we=%b expected 100/0000/0", ad, st, we);
        end
        checks++;
        if (dm !== exp_dmem) begin
            errors++; $display("FAIL lw_data: got %h expected %h", dm, exp_dmem);
        end
        @(negedge clk_MemAcc);
        checks++;
        if (stall_MemAcc !== 1'b0 || bus_req !== 1'b0) begin
            errors++; $display("FAIL lw_after: stall=%b req=%b expected 0/0", stall_MemAcc, bus_req);
        end
        @(posedge clk_MemAcc); #1;
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b101, 3'b001};
        logic [31:0] as  [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
        logic [31:0] exs [4] = '{32'hFFFFFF80, 32'h00000080, 32'h000080AA, 32'hFFFF80AA};
        int sn, rn, un; logic mis, we, ok; logic [31:0] ad, wd, dm; logic [3:0] st;
        for (int i = 0; i < 4; i++) begin
            run_access(1, 1, 0, f3s[i], as[i], 32'h0, 32'h80AA5511, i,
                       sn, rn, mis, ad, wd, st, we, un, dm, ok);
            exp_dmem = exs[i];
            checks++;
            if (!ok || sn != i + 2 || un != 0) begin
                errors++; $display("FAIL ld_ext_timing[%0d]: stall=%0d unstable=%0d expected %0d/0", i, sn, un, i + 2);
            end
            checks++;
            if (dm !== exp_dmem) begin
                errors++; $display("FAIL ld_ext_data[%0d]: got %h expected %h", i, dm, exp_dmem);
            end
        end
    endtask

    task automatic test_store();
        logic [31:0] as  [2] = '{32'h201, 32'h202};
        logic [2:0]  f3s [2] = '{3'b000, 3'b001};
        logic [3:0]  exs [2] = '{4'b0010, 4'b1100};
        logic [31:0] exw [2] = '{32'h78787878, 32'h56785678};
        logic [31:0] exa [2] = '{32'h200, 32'h200};
        int sn, rn, un; logic mis, we, ok; logic [31:0] ad, wd, dm; logic [3:0] st;
        for (int i = 0; i < 2; i++) begin
            run_access(1, 0, 1, f3s[i], as[i], 32'h12345678, 32'hCAFEF00D, 1,
                       sn, rn, mis, ad, wd, st, we, un, dm, ok);
            checks++;
            if (ad !== exa[i] || st !== exs[i] || wd !== exw[i] || we !== 1'b1) begin
                errors++; $display("FAIL store_bus[%0d]: addr=%h strb=%b wdata=%h we=%b expected %h/%b/%h/1",
                                   i, ad, st, wd, we, exa[i], exs[i], exw[i]);
            end
            checks++;
            if (!ok || sn != 3 || dm !== exp_dmem) begin
                errors++; $display("FAIL store_done[%0d]: stall=%0d dmem=%h expected 3/%h", i, sn, dm, exp_dmem);
            end
        end
    endtask

    task automatic test_misalign();
        logic [2:0]  f3s [3] = '{3'b010, 3'b001, 3'b011};
        logic [31:0] as  [3] = '{32'h102, 32'h101, 32'h100};
        int sn, rn, un; logic mis, we, ok; logic [31:0] ad, wd, dm; logic [3:0] st;
        for (int i = 0; i < 3; i++) begin
            run_access(1, 1, 0, f3s[i], as[i], 32'h0, 32'h11111111, 0,
                       sn, rn, mis, ad, wd, st, we, un, dm, ok);
            checks++;
            if (mis !== 1'b1 || sn != 0 || rn != 0 || dm !== exp_dmem) begin
                errors++; $display("FAIL misalign[%0d]: mis=%b stall=%0d req=%0d dmem=%h expected 1/0/0/%h",
                                   i, mis, sn, rn, dm, exp_dmem);
            end
            @(negedge clk_MemAcc);
            checks++;
            if (bus_req !== 1'b0 || stall_MemAcc !== 1'b0) begin
                errors++; $display("FAIL misalign_after[%0d]: req=%b stall=%b expected 0/0", i, bus_req, stall_MemAcc);
            end
            @(posedge clk_MemAcc); #1;
        end
    endtask

    task automatic test_random();
        logic [2:0] f3_tab [12] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
        int sn, rn, un, k, op; logic mis, we, ok, vld, rd, wr, access, emis;
        logic [31:0] ad, wd, dm, a, d, r; logic [3:0] st; logic [2:0] f3;
        for (int it = 0; it < 60; it++) begin
            vld = ($urandom_range(0, 7) != 0);
            op  = $urandom_range(0, 4);
            rd  = (op == 1 || op == 2);
            wr  = (op == 3 || op == 4);
            f3  = f3_tab[$urandom_range(0, 11)];
            a   = $urandom; d = $urandom; r = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & ~(32'(model_size(f3)) - 1);
            k   = $urandom_range(0, 4);
            emis   = vld && (rd || wr) && model_bad(f3, a);
            access = vld && (rd || wr) && !emis;
            run_access(vld, rd, wr, f3, a, d, r, k, sn, rn, mis, ad, wd, st, we, un, dm, ok);
            if (access && rd) exp_dmem = model_load(f3, a, r);
            checks++;
            if (mis !== emis || !ok || sn != (access ? k + 2 : 0) || rn != (access ? k + 1 : 0) || un != 0) begin
                errors++; $display("FAIL rand_ctrl[%0d]: mis=%b stall=%0d req=%0d unstable=%0d expected %b/%0d/%0d/0",
                                   it, mis, sn, rn, un, emis, access ? k + 2 : 0, access ? k + 1 : 0);
            end
            checks++;
            if (access && (ad !== {a[31:2], 2'b00} || we !== wr ||
                           st !== (wr ? model_strb(f3, a) : 4'b0000) ||
                           (wr && wd !== model_wdata(f3, d)))) begin
                errors++; $display("FAIL rand_bus[%0d]: addr=%h we=%b strb=%b wdata=%h expected %h/%b/%b/%h",
                                   it, ad, we, st, wd, {a[31:2], 2'b00}, wr,
                                   wr ? model_strb(f3, a) : 4'b0000, model_wdata(f3, d));
            end
            checks++;
            if (dm !== exp_dmem) begin
                errors++; $display("FAIL rand_data[%0d]: got %h expected %h", it, dm, exp_dmem);
            end
        end
    endtask

    task automatic test_timeout();
        int sn, rn, un; logic mis, we, ok; logic [31:0] ad, wd, dm; logic [3:0] st;
        run_access(1, 1, 0, 3'b010, 32'h300, 32'h0, 32'h55555555, 1000,
                   sn, rn, mis, ad, wd, st, we, un, dm, ok);
        exp_dmem = 32'h0;
        checks++;
        if (!ok || rn != TMO || sn != TMO + 1) begin
            errors++; $display("FAIL timeout_timing: done=%b req=%0d stall=%0d expected 1/%0d/%0d", ok, rn, sn, TMO, TMO + 1);
        end
        checks++;
        if (bus_err_MemAcc !== 1'b1 || dm !== exp_dmem) begin
            errors++; $display("FAIL timeout_err: err=%b dmem=%h expected 1/%h", bus_err_MemAcc, dm, exp_dmem);
        end
        run_access(1, 1, 0, 3'b010, 32'h304, 32'h0, 32'h0BADF00D, 2,
                   sn, rn, mis, ad, wd, st, we, un, dm, ok);
        exp_dmem = 32'h0BADF00D;
        checks++;
        if (bus_err_MemAcc !== 1'b1 || dm !== exp_dmem || sn != 4) begin
            errors++; $display("FAIL err_sticky: err=%b dmem=%h stall=%0d expected 1/%h/4", bus_err_MemAcc, dm, sn, exp_dmem);
        end
    endtask

    task automatic test_reset_mid_access();
        int sn, rn, un; logic mis, we, ok; logic [31:0] ad, wd, dm; logic [3:0] st;
        valid_MemAcc = 1'b1; MemRead_MemAcc = 1'b1; MemWrite_MemAcc = 1'b0;
        funct3_MemAcc = 3'b010; ALU_in_MemAcc = 32'h400; bus_rdata = 32'h77777777;
        repeat (3) @(negedge clk_MemAcc);
        checks++;
        if (bus_req !== 1'b1 || stall_MemAcc !== 1'b1) begin
            errors++; $display("FAIL midrst_pre: req=%b stall=%b expected 1/1", bus_req, stall_MemAcc);
        end
        #1 rstn_MemAcc = 1'b0;
        #1;
        exp_dmem = 32'h0;
        checks++;
        if (bus_req !== 1'b0 || stall_MemAcc !== 1'b0 || bus_err_MemAcc !== 1'b0 || DMem_data_MemAcc !== exp_dmem) begin
            errors++; $display("FAIL midrst_now: req=%b stall=%b err=%b dmem=%h expected 0/0/0/0",
                               bus_req, stall_MemAcc, bus_err_MemAcc, DMem_data_MemAcc);
        end
        valid_MemAcc = 1'b0; MemRead_MemAcc = 1'b0;
        @(posedge clk_MemAcc); #1;
        rstn_MemAcc = 1'b1;
        @(negedge clk_MemAcc);
        bus_ack = 1'b1;
        @(posedge clk_MemAcc); #1;
        bus_ack = 1'b0;
        @(negedge clk_MemAcc);
        checks++;
        if (stall_MemAcc !== 1'b0 || bus_req !== 1'b0 || DMem_data_MemAcc !== exp_dmem) begin
            errors++; $display("FAIL late_ack: stall=%b req=%b dmem=%h expected 0/0/%h",
                               stall_MemAcc, bus_req, DMem_data_MemAcc, exp_dmem);
        end
        @(posedge clk_MemAcc); #1;
        run_access(1, 1, 0, 3'b000, 32'h402, 32'h0, 32'h00FE0000, 1,
                   sn, rn, mis, ad, wd, st, we, un, dm, ok);
        exp_dmem = 32'hFFFFFFFE;
        checks++;
        if (!ok || sn != 3 || dm !== exp_dmem) begin
            errors++; $display("FAIL post_reset_access: stall=%0d dmem=%h expected 3/%h", sn, dm, exp_dmem);
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_ext();
        test_store();
        test_misalign();
        test_random();
        test_timeout();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
